// File: rtl/button_ctrl.sv
// Multi-channel push-button controller: synchronizes, debounces and classifies
// each button into press, release, long-press and auto-repeat pulses.
module button_ctrl #(
  parameter int N          = 2,
  parameter int DB_TICKS   = 10,
  parameter int LONG_TICKS = 1000,
  parameter int RPT_TICKS  = 200,
  parameter int RPT_EN     = 1
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         tick,
  input  logic [N-1:0] btnRaw,
  output logic [N-1:0] btnDb,
  output logic [N-1:0] pressPls,
  output logic [N-1:0] releasePls,
  output logic [N-1:0] longPls,
  output logic [N-1:0] rptPls
);

  localparam int DB_W     = $clog2(DB_TICKS);
  localparam int HOLD_MAX = (LONG_TICKS > RPT_TICKS) ? LONG_TICKS : RPT_TICKS;
  localparam int HOLD_W   = $clog2(HOLD_MAX);

  // Counters compare against "last value before threshold" so they never need
  // to hold the threshold itself and cannot wrap.
  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DB_TICKS - 1);
  localparam logic [HOLD_W-1:0] LONG_LAST = HOLD_W'(LONG_TICKS - 1);
  localparam logic [HOLD_W-1:0] RPT_LAST  = HOLD_W'(RPT_TICKS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRESS = 2'd1,
    HOLD  = 2'd2
  } state_t;

  for (genvar i = 0; i < N; i++) begin : g_ch
    logic              sync1;
    logic              sync2;
    logic [DB_W-1:0]   db_cnt;
    logic              db;
    logic [HOLD_W-1:0] hold_cnt;
    state_t            state;
    logic              press_q;
    logic              release_q;
    logic              long_q;
    logic              rpt_q;
    logic              db_flip;
    logic              rise;
    logic              fall;

    // The debounced level changes on the tick that completes DB_TICKS
    // consecutive differing samples; rise/fall are that same event.
    assign db_flip = tick && (sync2 != db) && (db_cnt == DB_LAST);
    assign rise    = db_flip && sync2;
    assign fall    = db_flip && !sync2;

    // NOTE: every clocked block uses non-blocking assignments so all per-channel
    // state samples pre-edge values and updates together at the edge.
    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        sync1 <= 1'b0;
        sync2 <= 1'b0;
      end else begin
        sync1 <= btnRaw[i];
        sync2 <= sync1;
      end
    end

    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        db_cnt <= '0;
        db     <= 1'b0;
      end else if (tick) begin
        if (sync2 == db) begin
          db_cnt <= '0;
        end else if (db_cnt == DB_LAST) begin
          db     <= sync2;
          db_cnt <= '0;
        end else begin
          db_cnt <= db_cnt + 1'b1;
        end
      end
    end

    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        state     <= IDLE;
        hold_cnt  <= '0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
        long_q    <= 1'b0;
        rpt_q     <= 1'b0;
      end else begin
        press_q   <= rise;
        release_q <= fall;
        long_q    <= 1'b0;
        rpt_q     <= 1'b0;
        // A fall is checked before any threshold so release always wins.
        case (state)
          IDLE: begin
            if (rise) begin
              state    <= PRESS;
              hold_cnt <= '0;
            end
          end
          PRESS: begin
            if (fall) begin
              state    <= IDLE;
              hold_cnt <= '0;
            end else if (tick) begin
              if (hold_cnt == LONG_LAST) begin
                long_q   <= 1'b1;
                hold_cnt <= '0;
                state    <= HOLD;
              end else begin
                hold_cnt <= hold_cnt + 1'b1;
              end
            end
          end
          HOLD: begin
            if (fall) begin
              state    <= IDLE;
              hold_cnt <= '0;
            end else if (tick && (RPT_EN != 0)) begin
              if (hold_cnt == RPT_LAST) begin
                rpt_q    <= 1'b1;
                hold_cnt <= '0;
              end else begin
                hold_cnt <= hold_cnt + 1'b1;
              end
            end
          end
          default: begin
            state    <= IDLE;
            hold_cnt <= '0;
          end
        endcase
      end
    end

    assign btnDb[i]      = db;
    assign pressPls[i]   = press_q;
    assign releasePls[i] = release_q;
    assign longPls[i]    = long_q;
    assign rptPls[i]     = rpt_q;
  end

endmodule

// File: tb/tb_button_ctrl.sv
// Bench for button_ctrl: two instances (repeat on / off) share stimulus; pulse
// events are checked against a scoreboard of expected tick numbers.
module tb_button_ctrl;

  localparam int N    = 2;
  localparam int DB   = 10;
  localparam int LONG = 50;
  localparam int RPT  = 20;

  logic         clk;
  logic         rstn;
  logic         tick;
  logic [N-1:0] btn_raw;
  logic [N-1:0] db_a, pr_a, rl_a, lg_a, rp_a;
  logic [N-1:0] db_b, pr_b, rl_b, lg_b, rp_b;

  button_ctrl #(.N(N), .DB_TICKS(DB), .LONG_TICKS(LONG), .RPT_TICKS(RPT), .RPT_EN(1)) dut_a (
    .clk(clk), .rstn(rstn), .tick(tick), .btnRaw(btn_raw),
    .btnDb(db_a), .pressPls(pr_a), .releasePls(rl_a), .longPls(lg_a), .rptPls(rp_a)
  );

  button_ctrl #(.N(N), .DB_TICKS(DB), .LONG_TICKS(LONG), .RPT_TICKS(RPT), .RPT_EN(0)) dut_b (
    .clk(clk), .rstn(rstn), .tick(tick), .btnRaw(btn_raw),
    .btnDb(db_b), .pressPls(pr_b), .releasePls(rl_b), .longPls(lg_b), .rptPls(rp_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    int         t;
    logic [1:0] pr;
    logic [1:0] rl;
    logic [1:0] lg;
    logic [1:0] rp;
  } ev_t;

  typedef struct {
    logic [1:0] raw;
    int         ticks;
    logic [1:0] db;
    int         off;
    logic [1:0] pr;
    logic [1:0] rl;
    logic [1:0] lg;
    logic [1:0] rp;
  } row_t;

  ev_t  q_a[$];
  ev_t  q_b[$];
  row_t tbl[$];
  ev_t  ea;
  ev_t  eb;
  int   checks  = 0;
  int   errors  = 0;
  int   tick_no = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic cmp_event(input string name, input ev_t got, input ev_t exp);
    checks++;
    if (got.t != exp.t || got.pr !== exp.pr || got.rl !== exp.rl ||
        got.lg !== exp.lg || got.rp !== exp.rp) begin
      errors++;
      $display("FAIL %s: got tick=%0d press=%b release=%b long=%b rpt=%b expected tick=%0d press=%b release=%b long=%b rpt=%b",
               name, got.t, got.pr, got.rl, got.lg, got.rp, exp.t, exp.pr, exp.rl, exp.lg, exp.rp);
    end
  endtask

  // Pulses are sampled on the falling edge; each one must match the head of its queue.
  always @(negedge clk) begin
    if (|{pr_a, rl_a, lg_a, rp_a}) begin
      if (q_a.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL dut_a_unexpected: tick=%0d press=%b release=%b long=%b rpt=%b expected no pulse",
                 tick_no, pr_a, rl_a, lg_a, rp_a);
      end else begin
        ea = q_a.pop_front();
        cmp_event("dut_a_event", '{tick_no, pr_a, rl_a, lg_a, rp_a}, ea);
      end
    end
    if (|{pr_b, rl_b, lg_b, rp_b}) begin
      if (q_b.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL dut_b_unexpected: tick=%0d press=%b release=%b long=%b rpt=%b expected no pulse",
                 tick_no, pr_b, rl_b, lg_b, rp_b);
      end else begin
        eb = q_b.pop_front();
        cmp_event("dut_b_event", '{tick_no, pr_b, rl_b, lg_b, rp_b}, eb);
      end
    end
  end

  // Three idle clocks let the synchronizer settle, then one single-cycle tick.
  task automatic do_tick();
    repeat (3) @(posedge clk);
    #1 tick = 1'b1;
    @(posedge clk);
    #1 tick = 1'b0;
    tick_no++;
  endtask

  function automatic row_t mk(input logic [1:0] raw, input int ticks, input logic [1:0] db,
                              input int off, input logic [1:0] pr, input logic [1:0] rl,
                              input logic [1:0] lg, input logic [1:0] rp);
    row_t r;
    r.raw = raw; r.ticks = ticks; r.db = db; r.off = off;
    r.pr = pr; r.rl = rl; r.lg = lg; r.rp = rp;
    return r;
  endfunction

  // Apply one row: drive raw, queue the expected event 'off' ticks in, run, check levels.
  task automatic run_row(input string name, input row_t r);
    ev_t e;
    int  t0;
    btn_raw = r.raw;
    t0      = tick_no;
    if (r.off > 0) begin
      e = '{t0 + r.off, r.pr, r.rl, r.lg, r.rp};
      q_a.push_back(e);
      if (|{r.pr, r.rl, r.lg}) begin
        e.rp = 2'b00;
        q_b.push_back(e);
      end
    end
    repeat (r.ticks) do_tick();
    check({name, "_db_a"}, 64'(db_a), 64'(r.db));
    check({name, "_db_b"}, 64'(db_b), 64'(r.db));
  endtask

  initial begin
    rstn    = 1'b1;
    tick    = 1'b0;
    btn_raw = 2'b00;

    // Single press on ch0 with ch1 idle, then release.
    tbl.push_back(mk(2'b00,  3, 2'b00,  0, 2'b00, 2'b00, 2'b00, 2'b00));
    tbl.push_back(mk(2'b01, 10, 2'b01, 10, 2'b01, 2'b00, 2'b00, 2'b00));
    tbl.push_back(mk(2'b01,  5, 2'b01,  0, 2'b00, 2'b00, 2'b00, 2'b00));
    tbl.push_back(mk(2'b00, 10, 2'b00, 10, 2'b00, 2'b01, 2'b00, 2'b00));
    // Nine differing ticks is one short of acceptance.
    tbl.push_back(mk(2'b10,  9, 2'b00,  0, 2'b00, 2'b00, 2'b00, 2'b00));
    tbl.push_back(mk(2'b00,  3, 2'b00,  0, 2'b00, 2'b00, 2'b00, 2'b00));
    tbl.push_back(mk(2'b10, 10, 2'b10, 10, 2'b10, 2'b00, 2'b00, 2'b00));
    tbl.push_back(mk(2'b00, 10, 2'b00, 10, 2'b00, 2'b10, 2'b00, 2'b00));
    tbl.push_back(mk(2'b11, 10, 2'b11, 10, 2'b11, 2'b00, 2'b00, 2'b00));
    tbl.push_back(mk(2'b00, 10, 2'b00, 10, 2'b00, 2'b11, 2'b00, 2'b00));
    // Bounce every 3 ticks for 30 ticks, then settle high.
    for (int k = 0; k < 10; k++)
      tbl.push_back(mk((k % 2 == 0) ? 2'b01 : 2'b00, 3, 2'b00, 0, 2'b00, 2'b00, 2'b00, 2'b00));
    tbl.push_back(mk(2'b01, 12, 2'b01, 10, 2'b01, 2'b00, 2'b00, 2'b00));
    tbl.push_back(mk(2'b00, 10, 2'b00, 10, 2'b00, 2'b01, 2'b00, 2'b00));
    // 120-tick hold: long at 50, repeats at 70/90/110. The release lands on
    // tick 130, exactly when the next repeat would fire.
    tbl.push_back(mk(2'b01, 10, 2'b01, 10, 2'b01, 2'b00, 2'b00, 2'b00));
    tbl.push_back(mk(2'b01, 50, 2'b01, 50, 2'b00, 2'b00, 2'b01, 2'b00));
    tbl.push_back(mk(2'b01, 20, 2'b01, 20, 2'b00, 2'b00, 2'b00, 2'b01));
    tbl.push_back(mk(2'b01, 20, 2'b01, 20, 2'b00, 2'b00, 2'b00, 2'b01));
    tbl.push_back(mk(2'b01, 20, 2'b01, 20, 2'b00, 2'b00, 2'b00, 2'b01));
    tbl.push_back(mk(2'b01, 10, 2'b01,  0, 2'b00, 2'b00, 2'b00, 2'b00));
    tbl.push_back(mk(2'b00, 10, 2'b00, 10, 2'b00, 2'b01, 2'b00, 2'b00));
    // Release accepted on the very tick the long-press would fire.
    tbl.push_back(mk(2'b01, 10, 2'b01, 10, 2'b01, 2'b00, 2'b00, 2'b00));
    tbl.push_back(mk(2'b01, 40, 2'b01,  0, 2'b00, 2'b00, 2'b00, 2'b00));
    tbl.push_back(mk(2'b00, 10, 2'b00, 10, 2'b00, 2'b01, 2'b00, 2'b00));
    tbl.push_back(mk(2'b00,  5, 2'b00,  0, 2'b00, 2'b00, 2'b00, 2'b00));

    #3 rstn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_a", 64'({db_a, pr_a, rl_a, lg_a, rp_a}), 64'd0);
    check("reset_b", 64'({db_b, pr_b, rl_b, lg_b, rp_b}), 64'd0);
    rstn = 1'b1;

    for (int i = 0; i < tbl.size(); i++)
      run_row($sformatf("row%0d", i), tbl[i]);

    // Reset while ch1 is in HOLD with the button still held.
    run_row("rst_press", mk(2'b10, 10, 2'b10, 10, 2'b10, 2'b00, 2'b00, 2'b00));
    run_row("rst_long",  mk(2'b10, 50, 2'b10, 50, 2'b00, 2'b00, 2'b10, 2'b00));
    run_row("rst_hold",  mk(2'b10,  5, 2'b10,  0, 2'b00, 2'b00, 2'b00, 2'b00));
    rstn = 1'b0;
    #2;
    check("midrst_a", 64'({db_a, pr_a, rl_a, lg_a, rp_a}), 64'd0);
    check("midrst_b", 64'({db_b, pr_b, rl_b, lg_b, rp_b}), 64'd0);
    repeat (3) @(posedge clk);
    #1;
    check("midrst_late_a", 64'({db_a, pr_a, rl_a, lg_a, rp_a}), 64'd0);
    check("midrst_late_b", 64'({db_b, pr_b, rl_b, lg_b, rp_b}), 64'd0);
    rstn = 1'b1;
    run_row("post_press", mk(2'b10, 10, 2'b10, 10, 2'b10, 2'b00, 2'b00, 2'b00));
    run_row("post_long",  mk(2'b10, 50, 2'b10, 50, 2'b00, 2'b00, 2'b10, 2'b00));
    run_row("post_rel",   mk(2'b00, 10, 2'b00, 10, 2'b00, 2'b10, 2'b00, 2'b00));

    repeat (4) @(posedge clk);
    #1;
    check("q_a_drained", 64'(q_a.size()), 64'd0);
    check("q_b_drained", 64'(q_b.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/button_ctrl.md
BUTTON_CTRL -- requirements
Module: button_ctrl

Interface
REQ-001 Parameter N, default 2: number of independent button channels, 1..16.
REQ-002 Parameter DB_TICKS, default 10: consecutive ticks of stable differing input needed to accept a change, 2..255.
REQ-003 Parameter LONG_TICKS, default 1000: ticks of continuous press before a long-press event, must exceed DB_TICKS.
REQ-004 Parameter RPT_TICKS, default 200: ticks between auto-repeat pulses after long-press, >=1.
REQ-005 Parameter RPT_EN, default 1: 1 enables auto-repeat, 0 disables it.
REQ-006 clk  input  1  system clock; the only clock.
REQ-007 rstn  input  1  asynchronous active-low reset.
REQ-008 tick  input  1  one-clk-wide timebase strobe (nominally 1 ms); all timing counts tick, not clk.
REQ-009 btnRaw  input  N  raw button levels, asynchronous to clk, 1 = pressed.
REQ-010 btnDb  output  N  debounced level per channel.
REQ-011 pressPls  output  N  one-clk pulse on debounced 0->1.
REQ-012 releasePls  output  N  one-clk pulse on debounced 1->0.
REQ-013 longPls  output  N  one-clk pulse when press reaches LONG_TICKS.
REQ-014 rptPls  output  N  one-clk pulse per repeat interval while held past long-press.

Function
REQ-015 Each btnRaw bit SHALL pass a 2-flop synchronizer clocked every clk; all logic uses synchronized value s[i].
REQ-016 Per channel, on a tick cycle: s[i]==btnDb[i] -> debounce counter cleared; else counter increments, and on the tick where counter == DB_TICKS-1, btnDb[i] <= s[i] and counter cleared.
REQ-017 Non-tick cycles SHALL leave debounce counters and hold counters unchanged.
REQ-018 A glitch shorter than DB_TICKS consecutive ticks SHALL not change btnDb; any tick with s==btnDb restarts the count.
REQ-019 pressPls[i]/releasePls[i] SHALL be registered and asserted in exactly the clk cycle in which btnDb[i] first shows its new value, for one cycle.
REQ-020 Per-channel FSM: IDLE (btnDb=0), PRESS (held, < LONG_TICKS), HOLD (long-press reached).
REQ-021 IDLE->PRESS on debounced rise; hold counter cleared to 0.
REQ-022 In PRESS, each tick increments hold counter; on the tick making it LONG_TICKS, longPls one cycle, counter cleared, go HOLD.
REQ-023 In HOLD with RPT_EN=1, each tick increments counter; on reaching RPT_TICKS, rptPls one cycle, counter cleared; with RPT_EN=0, rptPls stays 0 and counter is frozen at 0.
REQ-024 Debounced fall from PRESS or HOLD SHALL go IDLE, clear hold counter, and emit only releasePls.
REQ-025 If debounced fall and a long/repeat threshold occur on the same tick, release wins: releasePls asserted, longPls/rptPls not asserted.
REQ-026 Channels SHALL be fully independent; simultaneous events on several channels produce simultaneous pulses.
REQ-027 Counter widths SHALL be $clog2 of their maximum count; no counter wraps (thresholds clear before overflow).
REQ-028 A tick held high for multiple clk cycles SHALL count once per cycle high (caller guarantees single-cycle tick).

Reset
REQ-029 rstn low SHALL asynchronously clear synchronizers, all counters, btnDb, all pulse outputs, and set every FSM to IDLE.
REQ-030 Reset asserted mid-press SHALL produce no releasePls on deassertion; a still-pressed button is re-debounced from 0 and yields a fresh pressPls.
REQ-031 Reset deassertion is assumed synchronous to clk externally; block adds no reset synchronizer.

Verification
REQ-032 N=2, DB_TICKS=10: btnRaw[0] rises, stable 10 ticks -> btnDb[0]=1 on the 10th tick after sync, pressPls[0] one cycle, channel 1 untouched.
REQ-033 Bounce: btnRaw[0] toggles every 3 ticks for 30 ticks then stays 1 -> exactly one pressPls[0], no releasePls[0].
REQ-034 LONG_TICKS=50, RPT_TICKS=20, hold 120 ticks past debounce -> longPls at tick 50, rptPls at 70, 90, 110; release -> one releasePls.
REQ-035 RPT_EN=0, same hold -> longPls once, zero rptPls.
REQ-036 Release debounced on the exact tick LONG_TICKS would fire -> releasePls only, no longPls.
REQ-037 rstn pulsed low while channel 1 in HOLD, button kept pressed -> all outputs 0 during reset, no releasePls, pressPls[1] after DB_TICKS ticks, longPls after a further LONG_TICKS.
